route_sched: RTL and testbench
==============================

// Module: route_sched
// PURPOSE
//  Multi-stop route scheduler between the host UART receiver and cmd_cntrl.
//  Host commands queue destination station IDs and start or stop the route.
//  The block issues one GO command per queued station, detects arrival (in_transit falls),
//  dwells DWELL_CYC cycles, then dispatches the next stop. It is the only source of cmd/cmd_rdy into cmd_cntrl.
// PARAMETERS
//  DEPTH      8           route queue entries (power of 2, >=2)
//  DWELL_CYC  25_000_000  dwell cycles at each station (0.5 s @ 50 MHz); >=1
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  asynchronous, active-low reset
//  host_rdy      in   1  host command valid (UART cmd_rdy)
//  host_cmd      in   8  [7:6] opcode, [5:0] station ID
//  clr_host_rdy  out  1  1-cycle consume pulse to UART
//  cmd           out  8  command to cmd_cntrl ({2'b01,ID}=GO, 8'h00=STOP)
//  cmd_rdy       out  1  command valid to cmd_cntrl; held until clr_cmd_rdy
//  clr_cmd_rdy   in   1  cmd_cntrl consumed cmd
//  in_transit    in   1  cmd_cntrl transit flag
//  busy          out  1  state != IDLE
//  dwell         out  1  high during DWELL
//  route_done    out  1  1-cycle pulse: last stop's dwell finished
//  q_ovf         out  1  1-cycle pulse: ENQ dropped, queue full
//  q_cnt         out  $clog2(DEPTH)+1  queued entries
// BEHAVIOUR
//  Reset: all outputs 0; cmd=8'h00; queue empty; state IDLE; dwell counter 0.
//  Host opcodes: 00 STOP, 01 RUN, 10 ENQ(ID), 11 FLUSH.
//   clr_host_rdy is asserted combinationally in any cycle with host_rdy=1. Exactly one command is consumed per pulse.
//  ENQ: push ID when not full, else drop and pulse q_ovf. Push and pop in the same cycle leave q_cnt unchanged.
//  FLUSH: empty the queue next edge; the current trip continues; on arrival, dwell then IDLE with no route_done.
//  States / transitions:
//   IDLE: RUN and !empty -> ISSUE. RUN when empty is ignored. STOP in IDLE is consumed with no action.
//   ISSUE: cmd={2'b01,head} and cmd_rdy=1 are registered. clr_cmd_rdy -> TRANSIT and cmd_rdy drops next edge.
//   TRANSIT: arrival = in_transit_q & ~in_transit (registered edge detect). Arrival pops the head -> DWELL.
//    A fall within the first cycle after entry is still valid.
//   DWELL: dwell=1 and the counter runs 0..DWELL_CYC-1. At terminal count: if !empty -> ISSUE, else pulse route_done -> IDLE.
//   STOPPING: cmd=8'h00, cmd_rdy=1; clr_cmd_rdy -> IDLE.
//  Host STOP in ISSUE/TRANSIT/DWELL goes to STOPPING. The GO in ISSUE is withdrawn same edge.
//   The queue is retained and the interrupted head is not popped. RUN later re-issues that head.
//  Host RUN while busy is consumed and ignored.
//  Simultaneous arrival and host STOP: STOP wins. Pop is suppressed and the next state is STOPPING.
//  Simultaneous ENQ and terminal dwell with an empty queue: the push lands first, so dispatch goes to ISSUE and no route_done.
//   This is the same-edge rule: ENQ push is visible to the empty check.
//  cmd_rdy never drops without clr_cmd_rdy, except when STOP preempts ISSUE.
//  Reset mid-route: everything returns to reset values immediately and the queue is lost.
// STRUCTURE
//  route_pkg: opcode localparams OP_STOP/OP_RUN/OP_ENQ/OP_FLUSH, GO_CMD=2'b01, STOP_CMD=2'b00, typedef enum sched_state_t.
//  Sub-module route_fifo: DEPTH x 6-bit circular FIFO with push/pop/flush, full/empty/count.
//   Pointer wrap uses $clog2(DEPTH) bits; count uses one extra bit.
//  Dwell counter width $clog2(DWELL_CYC); it is cleared on entry to DWELL.
// TESTING (DWELL_CYC=16, DEPTH=4; bench models cmd_cntrl: clr_cmd_rdy 1 cycle after cmd_rdy,
//          in_transit set on clr, cleared on bench-driven arrival)
//  ENQ 5, ENQ 9, RUN -> GO 8'h45, arrive, dwell 16 cycles, GO 8'h49, arrive, dwell, route_done pulse, q_cnt=0.
//  5 ENQs into DEPTH=4 -> 4 accepted, 5th gives a single q_ovf pulse, q_cnt=4. Later pops exercise pointer wrap.
//  STOP mid-TRANSIT to ID 7 -> cmd 8'h00 issued, IDLE, q_cnt unchanged. RUN re-issues GO 8'h47.
//  Arrival and host STOP on the same cycle -> STOPPING, no pop, no dwell.
//  FLUSH during TRANSIT with 3 queued -> q_cnt=0, trip completes, dwell, IDLE, no route_done.
//  rst_n low during DWELL -> all outputs 0 asynchronously, q_cnt=0. RUN after reset is ignored.

Source files
------------

// File: rtl/route_pkg.sv
// Shared definitions for the multi-stop route scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package route_pkg;

  // Host opcodes, carried in host_cmd[7:6]
  localparam logic [1:0] OP_STOP  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_ENQ   = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;

  // Command prefixes towards cmd_cntrl, carried in cmd[7:6]
  localparam logic [1:0] GO_CMD   = 2'b01;
  localparam logic [1:0] STOP_CMD = 2'b00;

  localparam int ID_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_TRANSIT,
    S_DWELL,
    S_STOPPING
  } sched_state_t;

endpackage

// File: rtl/route_fifo.sv
// Circular FIFO of station IDs with synchronous flush and occupancy count.
// Latency: push visible at head one cycle later; head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty, flush overrides both.
// Ports: clk, rst_n; push/push_dat, pop, flush in; head, full, empty, cnt out.
module route_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: cnt gates every use of the contents
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/route_sched.sv
// Multi-stop route scheduler: queues host station IDs, issues one GO per stop,
//   waits for arrival (in_transit falling), dwells DWELL_CYC cycles, then moves on.
// Latency: host command acted on at the next edge; GO/STOP presented one cycle after the decision.
// Backpressure: cmd/cmd_rdy held until clr_cmd_rdy (a host STOP may replace a pending GO);
//   host commands are always consumed in the cycle they arrive.
// Ports: clk, rst_n; host_rdy/host_cmd in, clr_host_rdy out; cmd/cmd_rdy out, clr_cmd_rdy in;
//   in_transit in; busy, dwell, route_done, q_ovf, q_cnt status out.
module route_sched
  import route_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DWELL_CYC = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     host_rdy,
  input  logic [7:0]               host_cmd,
  output logic                     clr_host_rdy,
  output logic [7:0]               cmd,
  output logic                     cmd_rdy,
  input  logic                     clr_cmd_rdy,
  input  logic                     in_transit,
  output logic                     busy,
  output logic                     dwell,
  output logic                     route_done,
  output logic                     q_ovf,
  output logic [$clog2(DEPTH):0]   q_cnt
);

  localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

  sched_state_t    state;
  sched_state_t    next_state;

  logic [1:0]      op;
  logic [ID_W-1:0] id;
  logic            host_stop;
  logic            host_run;
  logic            host_enq;
  logic            host_flush;

  logic            fifo_full;
  logic            fifo_empty;
  logic [ID_W-1:0] fifo_head;
  logic            push;
  logic            pop;

  logic            in_transit_q;
  logic            arrival;
  logic [DW-1:0]   dwell_cnt;
  logic            dwell_term;
  logic            avail;
  logic [ID_W-1:0] next_head;
  logic [ID_W-1:0] go_id;
  logic            flushed;
  logic            issue_entry;

  // ---------------- host command decode ----------------
  assign op           = host_cmd[7:6];
  assign id           = host_cmd[ID_W-1:0];
  assign clr_host_rdy = host_rdy;
  assign host_stop    = host_rdy && (op == OP_STOP);
  assign host_run     = host_rdy && (op == OP_RUN);
  assign host_enq     = host_rdy && (op == OP_ENQ);
  assign host_flush   = host_rdy && (op == OP_FLUSH);

  // ---------------- route queue ----------------
  assign push = host_enq && !fifo_full;
  // STOP on the arrival cycle keeps the interrupted head for a later RUN
  assign pop  = (state == S_TRANSIT) && arrival && !host_stop;

  route_fifo #(
    .DEPTH (DEPTH),
    .W     (ID_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (id),
    .pop      (pop),
    .flush    (host_flush),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .cnt      (q_cnt)
  );

  // A same-cycle ENQ counts as queued; a same-cycle FLUSH discards what is queued
  assign avail     = (!fifo_empty && !host_flush) || push;
  assign next_head = fifo_empty ? id : fifo_head;

  // ---------------- arrival and dwell timing ----------------
  assign arrival    = in_transit_q && !in_transit;
  assign dwell_term = (state == S_DWELL) && (dwell_cnt == DW'(DWELL_CYC - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (host_run && !fifo_empty) next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (host_stop)        next_state = S_STOPPING;
        else if (clr_cmd_rdy) next_state = S_TRANSIT;
      end
      S_TRANSIT: begin
        if (host_stop)    next_state = S_STOPPING;
        else if (arrival) next_state = S_DWELL;
      end
      S_DWELL: begin
        if (host_stop)       next_state = S_STOPPING;
        else if (dwell_term) next_state = avail ? S_ISSUE : S_IDLE;
      end
      S_STOPPING: begin
        if (clr_cmd_rdy) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy    = (state != S_IDLE);
    dwell   = (state == S_DWELL);
    cmd_rdy = (state == S_ISSUE) || (state == S_STOPPING);
    cmd     = {STOP_CMD, {ID_W{1'b0}}};
    if (state == S_ISSUE) cmd = {GO_CMD, go_id};
  end

  // ---------------- datapath registers ----------------
  assign issue_entry = (next_state == S_ISSUE) && (state != S_ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_transit_q <= 1'b0;
      dwell_cnt    <= '0;
      go_id        <= '0;
      flushed      <= 1'b0;
      route_done   <= 1'b0;
      q_ovf        <= 1'b0;
    end else begin
      in_transit_q <= in_transit;

      // Held at zero outside DWELL, so every visit starts counting from 0
      if (state == S_DWELL) dwell_cnt <= dwell_cnt + 1'b1;
      else                  dwell_cnt <= '0;

      // Latch the GO target so a FLUSH during ISSUE cannot change cmd under cmd_rdy
      if (issue_entry) go_id <= next_head;

      // A route emptied by FLUSH finishes its current trip silently
      if ((next_state == S_IDLE) || issue_entry) flushed <= 1'b0;
      else if (host_flush && (state != S_IDLE))  flushed <= 1'b1;

      route_done <= dwell_term && !host_stop && !avail && !flushed && !host_flush;
      q_ovf      <= host_enq && fifo_full;
    end
  end

endmodule

// File: tb/tb_route_sched.sv
// Self-checking bench for route_sched (DEPTH=4, DWELL_CYC=16) with a cmd_cntrl model.
// Expected commands are queued by the stimulus and consumed by a monitor at each handshake.
// Status outputs are compared directly against hand-computed values.
module tb_route_sched;
  import route_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_rdy = 1'b0;
  logic [7:0] host_cmd = 8'h00;
  logic       clr_host_rdy;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       clr_cmd_rdy = 1'b0;
  logic       in_transit;
  logic       busy;
  logic       dwell;
  logic       route_done;
  logic       q_ovf;
  logic [2:0] q_cnt;

  route_sched #(.DEPTH(4), .DWELL_CYC(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_rdy     (host_rdy),
    .host_cmd     (host_cmd),
    .clr_host_rdy (clr_host_rdy),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .in_transit   (in_transit),
    .busy         (busy),
    .dwell        (dwell),
    .route_done   (route_done),
    .q_ovf        (q_ovf),
    .q_cnt        (q_cnt)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         rd_cnt = 0;
  int         ovf_cnt = 0;
  int         dwell_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_c;

  // cmd_cntrl model: in_transit rises with the GO ack and falls when the bench bumps arr_cnt
  int   arr_cnt = 0;
  int   go_tag = -1;
  logic mdl_transit = 1'b0;
  assign in_transit = mdl_transit && (arr_cnt == go_tag);

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) clr_cmd_rdy = 1'b0;
      else if (clr_cmd_rdy) clr_cmd_rdy = 1'b0;
      else if (cmd_rdy) begin
        clr_cmd_rdy = 1'b1;
        if (cmd[7:6] == GO_CMD) begin
          mdl_transit = 1'b1;
          go_tag      = arr_cnt;
        end else begin
          mdl_transit = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard on every command handshake, plus pulse counters
  always @(negedge clk) begin
    if (route_done) rd_cnt++;
    if (q_ovf) ovf_cnt++;
    if (dwell) dwell_seen++;
    if (cmd_rdy && clr_cmd_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_cmd unexpected act=%02h exp=none", cmd);
      end else begin
        exp_c = exp_q.pop_front();
        if (cmd !== exp_c) begin
          errors++;
          $display("FAIL sb_cmd act=%02h exp=%02h", cmd, exp_c);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host(input logic [1:0] op, input logic [5:0] id);
    host_rdy = 1'b1;
    host_cmd = {op, id};
    @(negedge clk);
    chk("clr_host_rdy", 32'(clr_host_rdy), 32'd1);
    @(posedge clk);
    #1;
    host_rdy = 1'b0;
    host_cmd = 8'h00;
  endtask

  task automatic arrive();
    arr_cnt++;
  endtask

  task automatic wait_transit();
    bit ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy && in_transit && !cmd_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_transit act=timeout exp=in_transit");
    end
    tick();
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle act=timeout exp=idle");
    end
    tick();
  endtask

  task automatic measure_dwell(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dwell) n++;
      else if (n > 0) break;
    end
    tick();
  endtask

  int n;
  int r0;
  int o0;
  int d0;

  initial begin
    // ---- reset state ----
    #7;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'h00);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_dwell", 32'(dwell), 32'd0);
    chk("rst_q_cnt", 32'(q_cnt), 32'd0);
    chk("rst_route_done", 32'(route_done), 32'd0);
    chk("rst_q_ovf", 32'(q_ovf), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // ---- two-stop route ----
    host(OP_ENQ, 6'd5);
    host(OP_ENQ, 6'd9);
    chk("t1_q_cnt2", 32'(q_cnt), 32'd2);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h49);
    host(OP_RUN, 6'd0);
    wait_transit();
    chk("t1_q_cnt_transit", 32'(q_cnt), 32'd2);
    arrive();
    measure_dwell(n);
    chk("t1_dwell_len1", 32'(n), 32'd16);
    chk("t1_q_cnt1", 32'(q_cnt), 32'd1);
    wait_transit();
    arrive();
    measure_dwell(n);
    chk("t1_dwell_len2", 32'(n), 32'd16);
    chk("t1_route_done", 32'(rd_cnt), 32'd1);
    chk("t1_q_cnt0", 32'(q_cnt), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // ---- overflow and pointer wrap ----
    o0 = ovf_cnt;
    r0 = rd_cnt;
    for (int i = 1; i <= 5; i++) host(OP_ENQ, 6'(i));
    tick();
    chk("t2_ovf_pulses", 32'(ovf_cnt - o0), 32'd1);
    chk("t2_q_cnt_full", 32'(q_cnt), 32'd4);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'h40 | 8'(i));
    host(OP_RUN, 6'd0);
    for (int i = 0; i < 4; i++) begin
      wait_transit();
      arrive();
    end
    wait_idle();
    tick();
    chk("t2_route_done", 32'(rd_cnt - r0), 32'd1);
    chk("t2_q_cnt0", 32'(q_cnt), 32'd0);

    // ---- STOP mid-transit, then resume ----
    r0 = rd_cnt;
    host(OP_ENQ, 6'd7);
    exp_q.push_back(8'h47);
    host(OP_RUN, 6'd0);
    wait_transit();
    chk("t3_q_cnt_transit", 32'(q_cnt), 32'd1);
    exp_q.push_back(8'h00);
    host(OP_STOP, 6'd0);
    wait_idle();
    chk("t3_q_cnt_kept", 32'(q_cnt), 32'd1);
    exp_q.push_back(8'h47);
    host(OP_RUN, 6'd0);
    wait_transit();
    arrive();
    wait_idle();
    tick();
    chk("t3_route_done", 32'(rd_cnt - r0), 32'd1);
    chk("t3_q_cnt0", 32'(q_cnt), 32'd0);

    // ---- arrival and STOP on the same cycle ----
    host(OP_ENQ, 6'd3);
    exp_q.push_back(8'h43);
    host(OP_RUN, 6'd0);
    wait_transit();
    d0 = dwell_seen;
    exp_q.push_back(8'h00);
    arrive();
    host(OP_STOP, 6'd0);
    chk("t4_no_dwell", 32'(dwell), 32'd0);
    wait_idle();
    chk("t4_dwell_never", 32'(dwell_seen - d0), 32'd0);
    chk("t4_no_pop", 32'(q_cnt), 32'd1);
    host(OP_FLUSH, 6'd0);
    chk("t4_flush_idle", 32'(q_cnt), 32'd0);

    // ---- FLUSH during transit ----
    r0 = rd_cnt;
    host(OP_ENQ, 6'd10);
    host(OP_ENQ, 6'd11);
    host(OP_ENQ, 6'd12);
    exp_q.push_back(8'h4A);
    host(OP_RUN, 6'd0);
    wait_transit();
    chk("t5_q_cnt3", 32'(q_cnt), 32'd3);
    host(OP_FLUSH, 6'd0);
    chk("t5_q_cnt_flushed", 32'(q_cnt), 32'd0);
    arrive();
    measure_dwell(n);
    chk("t5_dwell_len", 32'(n), 32'd16);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_no_route_done", 32'(rd_cnt - r0), 32'd0);

    // ---- ENQ on terminal dwell cycle with empty queue ----
    r0 = rd_cnt;
    host(OP_ENQ, 6'd20);
    exp_q.push_back(8'h54);
    exp_q.push_back(8'h55);
    host(OP_RUN, 6'd0);
    wait_transit();
    arrive();
    repeat (16) @(posedge clk);
    #1;
    host(OP_ENQ, 6'd21);
    tick();
    chk("t6_no_early_done", 32'(rd_cnt - r0), 32'd0);
    chk("t6_still_busy", 32'(busy), 32'd1);
    wait_transit();
    arrive();
    wait_idle();
    tick();
    chk("t6_route_done", 32'(rd_cnt - r0), 32'd1);

    // ---- reset during dwell ----
    host(OP_ENQ, 6'd1);
    host(OP_ENQ, 6'd2);
    exp_q.push_back(8'h41);
    host(OP_RUN, 6'd0);
    wait_transit();
    arrive();
    repeat (5) tick();
    chk("t7_in_dwell", 32'(dwell), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_dwell", 32'(dwell), 32'd0);
    chk("t7_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("t7_cmd", 32'(cmd), 32'h00);
    chk("t7_q_cnt", 32'(q_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    host(OP_RUN, 6'd0);
    repeat (4) tick();
    chk("t7_run_ignored", 32'(busy), 32'd0);
    chk("t7_no_cmd", 32'(cmd_rdy), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
